// File: rtl/axi4_arbiter_2to1.sv
// axi4_arbiter_2to1
// Shares one downstream AXI4 port between two upstream masters (s0, s1).
// AW and AR are granted round-robin, and a grant is held until its handshake.
// W follows the winning AW source until its last beat. B and R are routed back
// using the source bit prepended to the downstream ID. Outstanding writes and
// reads are each capped at MAX_OUT.
// Ports:
//   clock, reset            single clock, asynchronous active-high reset
//   sN_aw/w/ar_*  (N=0,1)   upstream request channels (valid/bits in, ready out)
//   sN_b/r_*                upstream response channels (valid/bits out, ready in)
//   m_aw/w/ar_*             downstream request channels, IDs are ID_W+1 wide
//   m_b/r_*                 downstream responses, ID MSB selects the destination
module axi4_arbiter_2to1 #(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                clock,
  input  logic                reset,
  // s0
  input  logic                s0_aw_valid,
  output logic                s0_aw_ready,
  input  logic [ID_W-1:0]     s0_aw_bits_id,
  input  logic [ADDR_W-1:0]   s0_aw_bits_addr,
  input  logic                s0_aw_bits_echo_real_last,
  input  logic                s0_w_valid,
  output logic                s0_w_ready,
  input  logic [DATA_W-1:0]   s0_w_bits_data,
  input  logic [DATA_W/8-1:0] s0_w_bits_strb,
  input  logic                s0_w_bits_last,
  input  logic                s0_b_ready,
  output logic                s0_b_valid,
  output logic [ID_W-1:0]     s0_b_bits_id,
  output logic [1:0]          s0_b_bits_resp,
  output logic                s0_b_bits_echo_real_last,
  input  logic                s0_ar_valid,
  output logic                s0_ar_ready,
  input  logic [ID_W-1:0]     s0_ar_bits_id,
  input  logic [ADDR_W-1:0]   s0_ar_bits_addr,
  input  logic                s0_ar_bits_echo_real_last,
  input  logic                s0_r_ready,
  output logic                s0_r_valid,
  output logic [ID_W-1:0]     s0_r_bits_id,
  output logic [DATA_W-1:0]   s0_r_bits_data,
  output logic [1:0]          s0_r_bits_resp,
  output logic                s0_r_bits_echo_real_last,
  output logic                s0_r_bits_last,
  // s1
  input  logic                s1_aw_valid,
  output logic                s1_aw_ready,
  input  logic [ID_W-1:0]     s1_aw_bits_id,
  input  logic [ADDR_W-1:0]   s1_aw_bits_addr,
  input  logic                s1_aw_bits_echo_real_last,
  input  logic                s1_w_valid,
  output logic                s1_w_ready,
  input  logic [DATA_W-1:0]   s1_w_bits_data,
  input  logic [DATA_W/8-1:0] s1_w_bits_strb,
  input  logic                s1_w_bits_last,
  input  logic                s1_b_ready,
  output logic                s1_b_valid,
  output logic [ID_W-1:0]     s1_b_bits_id,
  output logic [1:0]          s1_b_bits_resp,
  output logic                s1_b_bits_echo_real_last,
  input  logic                s1_ar_valid,
  output logic                s1_ar_ready,
  input  logic [ID_W-1:0]     s1_ar_bits_id,
  input  logic [ADDR_W-1:0]   s1_ar_bits_addr,
  input  logic                s1_ar_bits_echo_real_last,
  input  logic                s1_r_ready,
  output logic                s1_r_valid,
  output logic [ID_W-1:0]     s1_r_bits_id,
  output logic [DATA_W-1:0]   s1_r_bits_data,
  output logic [1:0]          s1_r_bits_resp,
  output logic                s1_r_bits_echo_real_last,
  output logic                s1_r_bits_last,
  // m
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ID_W:0]       m_aw_bits_id,
  output logic [ADDR_W-1:0]   m_aw_bits_addr,
  output logic                m_aw_bits_echo_real_last,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_bits_data,
  output logic [DATA_W/8-1:0] m_w_bits_strb,
  output logic                m_w_bits_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W:0]       m_b_bits_id,
  input  logic [1:0]          m_b_bits_resp,
  input  logic                m_b_bits_echo_real_last,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ID_W:0]       m_ar_bits_id,
  output logic [ADDR_W-1:0]   m_ar_bits_addr,
  output logic                m_ar_bits_echo_real_last,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [ID_W:0]       m_r_bits_id,
  input  logic [DATA_W-1:0]   m_r_bits_data,
  input  logic [1:0]          m_r_bits_resp,
  input  logic                m_r_bits_echo_real_last,
  input  logic                m_r_bits_last
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_BURST = 1'b1;

  logic [0:0]       wStateQ;
  logic             wSrcQ, awRrQ, arRrQ;
  logic             awHoldQ, arHoldQ, awHoldSrcQ, arHoldSrcQ;
  logic [CNT_W-1:0] wCntQ, wCntD, rCntQ, rCntD;

  logic awEligible, arEligible, awSrc, arSrc;
  logic awFire, arFire, wLastFire, bDec, rDec, bDst, rDst;

  // AW: a held grant overrides round-robin so the other source cannot preempt.
  assign awEligible = (wStateQ == W_IDLE) && (wCntQ < MaxCnt);
  assign awSrc = awHoldQ ? awHoldSrcQ :
                 ((s0_aw_valid && s1_aw_valid) ? awRrQ : s1_aw_valid);
  assign m_aw_valid = awEligible && (awSrc ? s1_aw_valid : s0_aw_valid);
  assign m_aw_bits_id = awSrc ? {1'b1, s1_aw_bits_id} : {1'b0, s0_aw_bits_id};
  assign m_aw_bits_addr = awSrc ? s1_aw_bits_addr : s0_aw_bits_addr;
  assign m_aw_bits_echo_real_last = awSrc ? s1_aw_bits_echo_real_last
                                          : s0_aw_bits_echo_real_last;
  assign s0_aw_ready = m_aw_valid && m_aw_ready && !awSrc;
  assign s1_aw_ready = m_aw_valid && m_aw_ready && awSrc;
  assign awFire = m_aw_valid && m_aw_ready;

  // AR: same scheme, throttled only by outstanding reads.
  assign arEligible = rCntQ < MaxCnt;
  assign arSrc = arHoldQ ? arHoldSrcQ :
                 ((s0_ar_valid && s1_ar_valid) ? arRrQ : s1_ar_valid);
  assign m_ar_valid = arEligible && (arSrc ? s1_ar_valid : s0_ar_valid);
  assign m_ar_bits_id = arSrc ? {1'b1, s1_ar_bits_id} : {1'b0, s0_ar_bits_id};
  assign m_ar_bits_addr = arSrc ? s1_ar_bits_addr : s0_ar_bits_addr;
  assign m_ar_bits_echo_real_last = arSrc ? s1_ar_bits_echo_real_last
                                          : s0_ar_bits_echo_real_last;
  assign s0_ar_ready = m_ar_valid && m_ar_ready && !arSrc;
  assign s1_ar_ready = m_ar_valid && m_ar_ready && arSrc;
  assign arFire = m_ar_valid && m_ar_ready;

  // W: locked to the source of the last granted AW while in W_BURST.
  assign m_w_valid = (wStateQ == W_BURST) && (wSrcQ ? s1_w_valid : s0_w_valid);
  assign m_w_bits_data = wSrcQ ? s1_w_bits_data : s0_w_bits_data;
  assign m_w_bits_strb = wSrcQ ? s1_w_bits_strb : s0_w_bits_strb;
  assign m_w_bits_last = wSrcQ ? s1_w_bits_last : s0_w_bits_last;
  assign s0_w_ready = (wStateQ == W_BURST) && !wSrcQ && m_w_ready;
  assign s1_w_ready = (wStateQ == W_BURST) && wSrcQ && m_w_ready;
  assign wLastFire = m_w_valid && m_w_ready && m_w_bits_last;

  // B / R: the prepended ID bit picks the upstream destination.
  assign bDst = m_b_bits_id[ID_W];
  assign s0_b_valid = m_b_valid && !bDst;
  assign s1_b_valid = m_b_valid && bDst;
  assign m_b_ready = bDst ? s1_b_ready : s0_b_ready;
  assign s0_b_bits_id = m_b_bits_id[ID_W-1:0];
  assign s1_b_bits_id = m_b_bits_id[ID_W-1:0];
  assign s0_b_bits_resp = m_b_bits_resp;
  assign s1_b_bits_resp = m_b_bits_resp;
  assign s0_b_bits_echo_real_last = m_b_bits_echo_real_last;
  assign s1_b_bits_echo_real_last = m_b_bits_echo_real_last;

  assign rDst = m_r_bits_id[ID_W];
  assign s0_r_valid = m_r_valid && !rDst;
  assign s1_r_valid = m_r_valid && rDst;
  assign m_r_ready = rDst ? s1_r_ready : s0_r_ready;
  assign s0_r_bits_id = m_r_bits_id[ID_W-1:0];
  assign s1_r_bits_id = m_r_bits_id[ID_W-1:0];
  assign s0_r_bits_data = m_r_bits_data;
  assign s1_r_bits_data = m_r_bits_data;
  assign s0_r_bits_resp = m_r_bits_resp;
  assign s1_r_bits_resp = m_r_bits_resp;
  assign s0_r_bits_echo_real_last = m_r_bits_echo_real_last;
  assign s1_r_bits_echo_real_last = m_r_bits_echo_real_last;
  assign s0_r_bits_last = m_r_bits_last;
  assign s1_r_bits_last = m_r_bits_last;

  // Decrements at zero are protocol errors and are dropped.
  assign bDec = m_b_valid && m_b_ready && (wCntQ != '0);
  assign rDec = m_r_valid && m_r_ready && m_r_bits_last && (rCntQ != '0);

  always_comb begin
    wCntD = wCntQ;
    if (awFire && !bDec) wCntD = wCntQ + OneCnt;
    else if (!awFire && bDec) wCntD = wCntQ - OneCnt;
  end

  always_comb begin
    rCntD = rCntQ;
    if (arFire && !rDec) rCntD = rCntQ + OneCnt;
    else if (!arFire && rDec) rCntD = rCntQ - OneCnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wStateQ    <= W_IDLE;
      wSrcQ      <= 1'b0;
      awRrQ      <= 1'b0;
      arRrQ      <= 1'b0;
      awHoldQ    <= 1'b0;
      arHoldQ    <= 1'b0;
      awHoldSrcQ <= 1'b0;
      arHoldSrcQ <= 1'b0;
      wCntQ      <= '0;
      rCntQ      <= '0;
    end else begin
      wCntQ <= wCntD;
      rCntQ <= rCntD;
      if (awFire) begin
        awRrQ   <= ~awSrc;
        wSrcQ   <= awSrc;
        wStateQ <= W_BURST;
        awHoldQ <= 1'b0;
      end else begin
        if (m_aw_valid) begin
          awHoldQ    <= 1'b1;
          awHoldSrcQ <= awSrc;
        end
        if (wLastFire) wStateQ <= W_IDLE;
      end
      if (arFire) begin
        arRrQ   <= ~arSrc;
        arHoldQ <= 1'b0;
      end else if (m_ar_valid) begin
        arHoldQ    <= 1'b1;
        arHoldSrcQ <= arSrc;
      end
    end
  end

endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
// Randomized bench for axi4_arbiter_2to1: masters keep requests stable until
// accepted, a simple slave returns B after W-last and multi-beat R after AR,
// and a transaction-level model predicts every output each cycle.
module tb_axi4_arbiter_2to1;

  localparam int unsigned ID_W = 4;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int MAX_OUT = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // upstream, indexed by source
  logic [1:0]        awValid, awReady, awEcho;
  logic [ID_W-1:0]   awId [2];
  logic [ADDR_W-1:0] awAddr [2];
  logic [1:0]        wValid, wReady, wLast;
  logic [DATA_W-1:0] wData [2];
  logic [STRB_W-1:0] wStrb [2];
  logic [1:0]        bReady, bValid, bEcho;
  logic [ID_W-1:0]   bId [2];
  logic [1:0]        bResp [2];
  logic [1:0]        arValid, arReady, arEcho;
  logic [ID_W-1:0]   arId [2];
  logic [ADDR_W-1:0] arAddr [2];
  logic [1:0]        rReady, rValid, rEcho, rLast;
  logic [ID_W-1:0]   rId [2];
  logic [DATA_W-1:0] rData [2];
  logic [1:0]        rResp [2];
  // downstream
  logic              mAwValid, mAwReady, mAwEcho;
  logic [ID_W:0]     mAwId;
  logic [ADDR_W-1:0] mAwAddr;
  logic              mWValid, mWReady, mWLast;
  logic [DATA_W-1:0] mWData;
  logic [STRB_W-1:0] mWStrb;
  logic              mBValid, mBReady, mBEcho;
  logic [ID_W:0]     mBId;
  logic [1:0]        mBResp;
  logic              mArValid, mArReady, mArEcho;
  logic [ID_W:0]     mArId;
  logic [ADDR_W-1:0] mArAddr;
  logic              mRValid, mRReady, mREcho, mRLast;
  logic [ID_W:0]     mRId;
  logic [DATA_W-1:0] mRData;
  logic [1:0]        mRResp;

  axi4_arbiter_2to1 #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .s0_aw_valid(awValid[0]), .s0_aw_ready(awReady[0]), .s0_aw_bits_id(awId[0]),
    .s0_aw_bits_addr(awAddr[0]), .s0_aw_bits_echo_real_last(awEcho[0]),
    .s0_w_valid(wValid[0]), .s0_w_ready(wReady[0]), .s0_w_bits_data(wData[0]),
    .s0_w_bits_strb(wStrb[0]), .s0_w_bits_last(wLast[0]),
    .s0_b_ready(bReady[0]), .s0_b_valid(bValid[0]), .s0_b_bits_id(bId[0]),
    .s0_b_bits_resp(bResp[0]), .s0_b_bits_echo_real_last(bEcho[0]),
    .s0_ar_valid(arValid[0]), .s0_ar_ready(arReady[0]), .s0_ar_bits_id(arId[0]),
    .s0_ar_bits_addr(arAddr[0]), .s0_ar_bits_echo_real_last(arEcho[0]),
    .s0_r_ready(rReady[0]), .s0_r_valid(rValid[0]), .s0_r_bits_id(rId[0]),
    .s0_r_bits_data(rData[0]), .s0_r_bits_resp(rResp[0]),
    .s0_r_bits_echo_real_last(rEcho[0]), .s0_r_bits_last(rLast[0]),
    .s1_aw_valid(awValid[1]), .s1_aw_ready(awReady[1]), .s1_aw_bits_id(awId[1]),
    .s1_aw_bits_addr(awAddr[1]), .s1_aw_bits_echo_real_last(awEcho[1]),
    .s1_w_valid(wValid[1]), .s1_w_ready(wReady[1]), .s1_w_bits_data(wData[1]),
    .s1_w_bits_strb(wStrb[1]), .s1_w_bits_last(wLast[1]),
    .s1_b_ready(bReady[1]), .s1_b_valid(bValid[1]), .s1_b_bits_id(bId[1]),
    .s1_b_bits_resp(bResp[1]), .s1_b_bits_echo_real_last(bEcho[1]),
    .s1_ar_valid(arValid[1]), .s1_ar_ready(arReady[1]), .s1_ar_bits_id(arId[1]),
    .s1_ar_bits_addr(arAddr[1]), .s1_ar_bits_echo_real_last(arEcho[1]),
    .s1_r_ready(rReady[1]), .s1_r_valid(rValid[1]), .s1_r_bits_id(rId[1]),
    .s1_r_bits_data(rData[1]), .s1_r_bits_resp(rResp[1]),
    .s1_r_bits_echo_real_last(rEcho[1]), .s1_r_bits_last(rLast[1]),
    .m_aw_valid(mAwValid), .m_aw_ready(mAwReady), .m_aw_bits_id(mAwId),
    .m_aw_bits_addr(mAwAddr), .m_aw_bits_echo_real_last(mAwEcho),
    .m_w_valid(mWValid), .m_w_ready(mWReady), .m_w_bits_data(mWData),
    .m_w_bits_strb(mWStrb), .m_w_bits_last(mWLast),
    .m_b_valid(mBValid), .m_b_ready(mBReady), .m_b_bits_id(mBId),
    .m_b_bits_resp(mBResp), .m_b_bits_echo_real_last(mBEcho),
    .m_ar_valid(mArValid), .m_ar_ready(mArReady), .m_ar_bits_id(mArId),
    .m_ar_bits_addr(mArAddr), .m_ar_bits_echo_real_last(mArEcho),
    .m_r_valid(mRValid), .m_r_ready(mRReady), .m_r_bits_id(mRId),
    .m_r_bits_data(mRData), .m_r_bits_resp(mRResp),
    .m_r_bits_echo_real_last(mREcho), .m_r_bits_last(mRLast)
  );

  int total = 0;
  int bad = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus mix, percentages.
  int pAw, pAr, pAwRdy, pArRdy, pW, pWRdy, pB, pBRdy, pR, pRRdy;

  // Transaction-level model state.
  int mdlWOut, mdlROut;        // outstanding writes / reads
  bit mdlWBusy;                // a W burst is owed
  int mdlWSrc, mdlWBeat, mdlWLen;
  logic [ID_W:0] mdlWId;
  int mdlAwNext, mdlArNext;    // preferred source when both request
  int mdlAwLock, mdlArLock;    // source of a stalled grant, -1 if none
  int awLen [2];
  logic [ID_W:0] bQ [$];       // completed writes awaiting B
  logic [ID_W:0] rIdQ [$];     // accepted reads awaiting R
  int rBeatsQ [$];

  task automatic setMix(input int aw, input int ar, input int awr, input int arr, input int w,
                        input int wr, input int b, input int br, input int r, input int rr);
    pAw = aw; pAr = ar; pAwRdy = awr; pArRdy = arr; pW = w;
    pWRdy = wr; pB = b; pBRdy = br; pR = r; pRRdy = rr;
  endtask

  task automatic zeroInputs();
    awValid = '0; awEcho = '0; wValid = '0; wLast = '0; bReady = '0;
    arValid = '0; arEcho = '0; rReady = '0;
    for (int s = 0; s < 2; s++) begin
      awId[s] = '0; awAddr[s] = '0; wData[s] = '0; wStrb[s] = '0;
      arId[s] = '0; arAddr[s] = '0;
    end
    mAwReady = 0; mWReady = 0; mArReady = 0;
    mBValid = 0; mBId = '0; mBResp = '0; mBEcho = 0;
    mRValid = 0; mRId = '0; mRData = '0; mRResp = '0; mREcho = 0; mRLast = 0;
  endtask

  task automatic applyReset();
    zeroInputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mdlWOut = 0; mdlROut = 0; mdlWBusy = 0; mdlWSrc = 0; mdlWBeat = 0; mdlWLen = 1;
    mdlWId = '0; mdlAwNext = 0; mdlArNext = 0; mdlAwLock = -1; mdlArLock = -1;
    bQ.delete(); rIdQ.delete(); rBeatsQ.delete();
  endtask

  task automatic checkQuiet(input string pfx);
    checkVal({pfx, "_s0_aw_ready"}, awReady[0], 0);
    checkVal({pfx, "_s1_aw_ready"}, awReady[1], 0);
    checkVal({pfx, "_s_w_ready"}, wReady, 0);
    checkVal({pfx, "_s_b_valid"}, bValid, 0);
    checkVal({pfx, "_s_ar_ready"}, arReady, 0);
    checkVal({pfx, "_s_r_valid"}, rValid, 0);
    checkVal({pfx, "_m_aw_valid"}, mAwValid, 0);
    checkVal({pfx, "_m_w_valid"}, mWValid, 0);
    checkVal({pfx, "_m_b_ready"}, mBReady, 0);
    checkVal({pfx, "_m_ar_valid"}, mArValid, 0);
    checkVal({pfx, "_m_r_ready"}, mRReady, 0);
  endtask

  function automatic int pickSrc(input int lock, input logic [1:0] v, input int next);
    if (lock >= 0) return lock;
    if (v == 2'b11) return next;
    return v[1] ? 1 : 0;
  endfunction

  // One clock: drive at +1 after the edge, check at +2, update model after the edge.
  task automatic doCycle();
    int aSrc, rSrc;
    bit expAw, expAr, expW, awFire, arFire, wFire, bFire, rFire;
    logic bd, rd;
    for (int s = 0; s < 2; s++) begin
      if (!awValid[s] && $urandom_range(0, 99) < pAw) begin
        awValid[s] = 1'b1; awId[s] = ID_W'($urandom()); awAddr[s] = ADDR_W'($urandom());
        awEcho[s] = 1'($urandom()); awLen[s] = $urandom_range(1, 4);
      end
      if (!arValid[s] && $urandom_range(0, 99) < pAr) begin
        arValid[s] = 1'b1; arId[s] = ID_W'($urandom()); arAddr[s] = ADDR_W'($urandom());
        arEcho[s] = 1'($urandom());
      end
      wValid[s] = $urandom_range(0, 99) < pW;
      wData[s] = $urandom();
      wStrb[s] = STRB_W'($urandom());
      wLast[s] = (mdlWBusy && mdlWSrc == s) ? (mdlWBeat == mdlWLen - 1) : 1'($urandom());
      bReady[s] = $urandom_range(0, 99) < pBRdy;
      rReady[s] = $urandom_range(0, 99) < pRRdy;
    end
    mAwReady = $urandom_range(0, 99) < pAwRdy;
    mArReady = $urandom_range(0, 99) < pArRdy;
    mWReady = $urandom_range(0, 99) < pWRdy;
    mBValid = (bQ.size() > 0) && ($urandom_range(0, 99) < pB);
    mBId = (bQ.size() > 0) ? bQ[0] : (ID_W + 1)'($urandom());
    mBResp = 2'($urandom()); mBEcho = 1'($urandom());
    mRValid = (rIdQ.size() > 0) && ($urandom_range(0, 99) < pR);
    mRId = (rIdQ.size() > 0) ? rIdQ[0] : (ID_W + 1)'($urandom());
    mRLast = (rIdQ.size() > 0) ? (rBeatsQ[0] == 1) : 1'($urandom());
    mRData = $urandom(); mRResp = 2'($urandom()); mREcho = 1'($urandom());
    #1;
    // AW
    aSrc = pickSrc(mdlAwLock, awValid, mdlAwNext);
    expAw = !mdlWBusy && (mdlWOut < MAX_OUT) && awValid[aSrc];
    checkVal("m_aw_valid", mAwValid, expAw);
    if (expAw) begin
      checkVal("m_aw_id", mAwId, {aSrc[0], awId[aSrc]});
      checkVal("m_aw_addr", mAwAddr, awAddr[aSrc]);
      checkVal("m_aw_echo", mAwEcho, awEcho[aSrc]);
    end
    checkVal("s0_aw_ready", awReady[0], expAw && aSrc == 0 && mAwReady);
    checkVal("s1_aw_ready", awReady[1], expAw && aSrc == 1 && mAwReady);
    // AR
    rSrc = pickSrc(mdlArLock, arValid, mdlArNext);
    expAr = (mdlROut < MAX_OUT) && arValid[rSrc];
    checkVal("m_ar_valid", mArValid, expAr);
    if (expAr) begin
      checkVal("m_ar_id", mArId, {rSrc[0], arId[rSrc]});
      checkVal("m_ar_addr", mArAddr, arAddr[rSrc]);
      checkVal("m_ar_echo", mArEcho, arEcho[rSrc]);
    end
    checkVal("s0_ar_ready", arReady[0], expAr && rSrc == 0 && mArReady);
    checkVal("s1_ar_ready", arReady[1], expAr && rSrc == 1 && mArReady);
    // W
    expW = mdlWBusy && wValid[mdlWSrc];
    checkVal("m_w_valid", mWValid, expW);
    if (expW) begin
      checkVal("m_w_data", mWData, wData[mdlWSrc]);
      checkVal("m_w_strb", mWStrb, wStrb[mdlWSrc]);
      checkVal("m_w_last", mWLast, wLast[mdlWSrc]);
    end
    checkVal("s0_w_ready", wReady[0], mdlWBusy && mdlWSrc == 0 && mWReady);
    checkVal("s1_w_ready", wReady[1], mdlWBusy && mdlWSrc == 1 && mWReady);
    // B
    bd = mBId[ID_W];
    checkVal("s0_b_valid", bValid[0], mBValid && !bd);
    checkVal("s1_b_valid", bValid[1], mBValid && bd);
    checkVal("m_b_ready", mBReady, bReady[bd]);
    if (mBValid) begin
      checkVal($sformatf("s%0d_b_id", bd), bId[bd], mBId[ID_W-1:0]);
      checkVal($sformatf("s%0d_b_resp", bd), bResp[bd], mBResp);
      checkVal($sformatf("s%0d_b_echo", bd), bEcho[bd], mBEcho);
    end
    // R
    rd = mRId[ID_W];
    checkVal("s0_r_valid", rValid[0], mRValid && !rd);
    checkVal("s1_r_valid", rValid[1], mRValid && rd);
    checkVal("m_r_ready", mRReady, rReady[rd]);
    if (mRValid) begin
      checkVal($sformatf("s%0d_r_id", rd), rId[rd], mRId[ID_W-1:0]);
      checkVal($sformatf("s%0d_r_data", rd), rData[rd], mRData);
      checkVal($sformatf("s%0d_r_last", rd), rLast[rd], mRLast);
      checkVal($sformatf("s%0d_r_resp", rd), rResp[rd], mRResp);
    end
    awFire = expAw && mAwReady;
    arFire = expAr && mArReady;
    wFire = expW && mWReady;
    bFire = mBValid && bReady[bd];
    rFire = mRValid && rReady[rd];
    @(posedge clock);
    #1;
    if (awFire) begin
      mdlAwNext = 1 - aSrc; mdlAwLock = -1;
      mdlWBusy = 1; mdlWSrc = aSrc; mdlWBeat = 0; mdlWLen = awLen[aSrc];
      mdlWId = {aSrc[0], awId[aSrc]};
      mdlWOut++;
      awValid[aSrc] = 1'b0;
    end else if (expAw) begin
      mdlAwLock = aSrc;
    end
    if (wFire) begin
      if (mdlWBeat == mdlWLen - 1) begin
        mdlWBusy = 0;
        bQ.push_back(mdlWId);
      end else begin
        mdlWBeat++;
      end
    end
    if (bFire) begin
      void'(bQ.pop_front());
      mdlWOut--;
    end
    if (arFire) begin
      mdlArNext = 1 - rSrc; mdlArLock = -1;
      rIdQ.push_back({rSrc[0], arId[rSrc]});
      rBeatsQ.push_back($urandom_range(1, 3));
      mdlROut++;
      arValid[rSrc] = 1'b0;
    end else if (expAr) begin
      mdlArLock = rSrc;
    end
    if (rFire) begin
      if (rBeatsQ[0] == 1) begin
        void'(rIdQ.pop_front());
        void'(rBeatsQ.pop_front());
        mdlROut--;
      end else begin
        rBeatsQ[0] = rBeatsQ[0] - 1;
      end
    end
  endtask

  initial begin
    // Reset with idle inputs: every valid/ready output quiet, counters clear.
    zeroInputs();
    reset = 1'b1;
    #12;
    checkQuiet("in_reset");
    applyReset();
    #1;
    checkQuiet("after_reset");
    checkVal("reset_wcnt", dut.wCntQ, 0);
    checkVal("reset_rcnt", dut.rCntQ, 0);
    checkVal("reset_wstate", dut.wStateQ, 0);
    @(posedge clock);
    #1;

    setMix(50, 50, 60, 60, 70, 70, 50, 70, 60, 70);
    repeat (1500) doCycle();
    // Slow B return keeps writes pinned at the outstanding limit.
    setMix(90, 90, 80, 30, 80, 80, 4, 80, 5, 80);
    repeat (800) doCycle();
    // Both sources always requesting with ready downstream: strict alternation.
    setMix(100, 100, 100, 100, 100, 100, 100, 100, 100, 100);
    repeat (400) doCycle();
    // Long AW/AR stalls exercise grant holding.
    setMix(60, 60, 15, 15, 70, 60, 60, 70, 60, 70);
    repeat (600) doCycle();

    // s1 write id=3 while s0 also offers W; reset lands during beat 2.
    applyReset();
    awValid[1] = 1'b1; awId[1] = 4'h3; awAddr[1] = 30'h123; wValid[0] = 1'b1;
    wData[0] = 32'hDEAD0000; mAwReady = 1'b1;
    #1;
    checkVal("dir_m_aw_id", mAwId, 5'h13);
    checkVal("dir_s1_aw_ready", awReady[1], 1);
    checkVal("dir_s0_w_ready_aw", wReady[0], 0);
    @(posedge clock);
    #1;
    awValid[1] = 1'b0; mAwReady = 1'b0;
    wValid[1] = 1'b1; wData[1] = 32'hA1; wLast[1] = 1'b0; mWReady = 1'b1;
    #1;
    checkVal("dir_beat1_valid", mWValid, 1);
    checkVal("dir_beat1_data", mWData, 32'hA1);
    checkVal("dir_beat1_s0_ready", wReady[0], 0);
    @(posedge clock);
    #1;
    wData[1] = 32'hA2;
    #1;
    checkVal("dir_beat2_data", mWData, 32'hA2);
    checkVal("dir_wcnt_busy", dut.wCntQ, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkVal("dir_rst_m_w_valid", mWValid, 0);
    checkVal("dir_rst_s1_w_ready", wReady[1], 0);
    checkVal("dir_rst_wstate", dut.wStateQ, 0);
    checkVal("dir_rst_wcnt", dut.wCntQ, 0);
    checkVal("dir_rst_rcnt", dut.rCntQ, 0);
    zeroInputs();
    #1;
    checkQuiet("dir_rst");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
